uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- 8-N-1 UART transmitter with a small input FIFO. It is the transmit-side counterpart of the existing UART receive path in uart_dft_top.
- Accepts bytes on a valid/ready handshake, buffers them, and serialises them LSB-first on `tx` at a fixed clocks-per-bit rate.
- Used to return status/response bytes to the host. It also drives the `rx` of uart_dft_top in loopback benches.

Parameters:
- CLKS_PER_BIT, 8, clock cycles per UART bit (8 x 20 ns = 160 ns at 50 MHz); must be >= 2.
- FIFO_DEPTH, 4, entries in the input FIFO; power of two, >= 2.
- CNT_W, log2(FIFO_DEPTH)+1, width of `fifo_count`; derived, do not override.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to transmit; sampled when tx_valid && tx_ready.
- tx_valid  input  1  producer has a byte; must hold tx_data stable until accepted.
- tx_ready  output  1  FIFO can accept; = (fifo_count != FIFO_DEPTH), from registered count only.
- tx  output  1  serial line; idle high; registered output.
- busy  output  1  high while the FSM is not in IDLE.
- fifo_count  output  CNT_W  number of bytes stored and not yet popped.

Behaviour:
- Reset (async, immediate):
  - tx=1, busy=0, fifo_count=0, tx_ready=1.
  - FSM=IDLE; bit counter and baud counter = 0.
  - FIFO pointers cleared; stored contents are discarded.
- Push: on a rising edge with tx_valid && tx_ready, write tx_data at the write pointer; pointer wraps modulo FIFO_DEPTH.
- Pop: occurs only on the edge where the FSM loads a new frame (IDLE->START or STOP->START); the read pointer wraps modulo FIFO_DEPTH.
- Count on the same edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- No push is possible when the count equals FIFO_DEPTH, even if a pop happens on that edge.
- Pop never occurs when the count is 0. A byte pushed into an empty FIFO is popped no earlier than the next edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count!=0, pop into the shift register, go to START, and drive tx=0 from that edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end:
    - if fifo_count!=0, pop and go directly to START (no idle gap);
    - else go to IDLE.
- Timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Latency from an accepting edge into an empty FIFO with the FSM idle: tx falls exactly 1 clock later.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every state/bit change. No fractional baud and no drift.
- busy=1 from the START-entry edge until the edge that returns the FSM to IDLE. Back-to-back frames keep busy=1 throughout.
- tx_valid while tx_ready=0: no effect; the byte stays with the producer.
- Reset mid-frame: tx returns high asynchronously. The partial frame is abandoned, not resumed. After release the FSM is IDLE and the FIFO is empty.

Test Plan:
- Single byte: push 0xA1 once at idle -> tx low 20 ns after the accept edge.
  - Bits at 160 ns each: 0(start), 1,0,0,0,0,1,0,1, 1(stop).
  - busy high for 1600 ns; fifo_count returns to 0 one cycle after accept.
- Back-to-back: push 0x55 then 0x0F on consecutive cycles -> the second start bit begins on the edge the first stop bit ends.
  - 3200 ns of continuous frames; busy never drops between them.
- FIFO full: hold tx_valid=1 with bytes 0x01..0x06.
  - 5 bytes accepted on 5 consecutive edges (the first is popped immediately); tx_ready drops with fifo_count=4.
  - tx_ready reasserts on the edge that pops 0x02 (1600 ns after the first start), and 0x06 is then accepted.
  - All six bytes appear in order on tx.
- Reset mid-frame: push 0xFF and 0x3C, assert rst during data bit 3 of 0xFF.
  - tx=1 and fifo_count=0 immediately.
  - After release tx stays high and busy stays 0 for >= 2000 ns (0x3C is never sent).
- Loopback: connect tx to uart_dft_top rx (same clk/rst, scan_enable=0), push 0xA1 -> led goes high after the stop bit is received.
- Reset values: hold rst=1 with tx_valid=1 and tx_data=0xAA -> tx=1, busy=0, fifo_count=0, no push recorded after release until the first post-reset edge.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// 8-N-1 UART transmitter fed by a small byte FIFO.
// Frames are LSB-first; back-to-back frames have no idle gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              push;
  logic              pop;
  logic              baud_end;
  logic              not_empty;

  assign tx_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push = tx_valid && tx_ready;
  assign baud_end = (baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign not_empty = (fifo_count != '0);

  // A pop is the frame-load event: leaving IDLE or ending STOP.
  always_comb begin
    pop = 1'b0;
    if (not_empty) begin
      if (state == IDLE) pop = 1'b1;
      if (state == STOP && baud_end) pop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10: fifo_count <= fifo_count + 1'b1;
        2'b01: fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      busy <= 1'b0;
      baud <= '0;
      bit_idx <= '0;
      shift <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          baud <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            tx <= 1'b0;
            busy <= 1'b1;
            state <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud <= '0;
            bit_idx <= '0;
            tx <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift <= shift >> 1;
              tx <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              tx <= 1'b0;
              state <= START;
            end else begin
              busy <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_fifo with an independent serial receiver.
module tb_uart_tx_fifo;

  localparam int CPB = 8;
  localparam int DEPTH = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int frame_errs = 0;
  logic [7:0] rx_q [$];

  always #10 clk = ~clk;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx(tx),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  logic [7:0] mon_b;
  logic       mon_sb;
  initial forever begin
    @(negedge tx);
    if (!rst) begin
      repeat (CPB / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        mon_b[i] = tx;
      end
      repeat (CPB) @(posedge clk);
      mon_sb = tx;
      if (!rst) begin
        rx_q.push_back(mon_b);
        if (mon_sb !== 1'b1) frame_errs++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'hAA;
    tick(3);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", tx_ready); end
    rst = 1'b0;
    #2;
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_release_count got=%0d exp=0", fifo_count); end
    tick(1);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL rst_first_push got=%0d exp=1", fifo_count); end
    tx_valid = 1'b0;
    tick(1);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rst_aa_start got=%b exp=0", tx); end
    tick(80);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_aa_done busy=%b exp=0", busy); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hAA) begin errors++; $display("FAIL rst_aa_rx n=%0d exp=1 byte AA", rx_q.size()); end
    rx_q.delete();
    tick(5);
  endtask

  task automatic test_single;
    logic [9:0] fr;
    fr = {1'b1, 8'hA1, 1'b0};
    tx_valid = 1'b1;
    tx_data = 8'hA1;
    tick(1);
    tx_valid = 1'b0;
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_cnt1 got=%0d exp=1", fifo_count); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_pre_tx got=%b exp=1", tx); end
    tick(1);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_latency tx=%b exp=0", tx); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_cnt0 got=%0d exp=0", fifo_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    for (int i = 0; i < 10; i++) begin
      tick(4);
      checks++; if (tx !== fr[i] || busy !== 1'b1) begin errors++; $display("FAIL single_bit%0d tx=%b busy=%b exp tx=%b busy=1", i, tx, busy, fr[i]); end
      tick(4);
    end
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL single_end busy=%b tx=%b exp 0/1", busy, tx); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA1) begin errors++; $display("FAIL single_rx n=%0d exp=1 byte A1", rx_q.size()); end
    rx_q.delete();
    tick(5);
  endtask

  task automatic test_back_to_back;
    logic bb;
    logic st;
    bb = 1'b0;
    st = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'h55;
    tick(1);
    tx_data = 8'h0F;
    tick(1);
    tx_valid = 1'b0;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_start1 tx=%b exp=0", tx); end
    for (int i = 1; i < 160; i++) begin
      tick(1);
      if (busy !== 1'b1) bb = 1'b1;
      if (i == 80 && tx !== 1'b0) st = 1'b1;
    end
    checks++; if (bb !== 1'b0) begin errors++; $display("FAIL b2b_busy dropped=%b exp=0", bb); end
    checks++; if (st !== 1'b0) begin errors++; $display("FAIL b2b_start2 late=%b exp=0", st); end
    tick(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end busy=%b exp=0", busy); end
    checks++; if (rx_q.size() != 2 || rx_q[0] !== 8'h55 || rx_q[1] !== 8'h0F) begin errors++; $display("FAIL b2b_rx n=%0d exp=2 bytes 55 0F", rx_q.size()); end
    rx_q.delete();
    tick(5);
  endtask

  task automatic test_full;
    logic [CW-1:0] exp_cnt [5];
    logic rdy;
    logic held;
    logic ord;
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    held = 1'b0;
    ord = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'h01;
    for (int k = 0; k < 5; k++) begin
      rdy = tx_ready;
      tick(1);
      checks++; if (fifo_count !== exp_cnt[k]) begin errors++; $display("FAIL full_cnt%0d got=%0d exp=%0d", k, fifo_count, exp_cnt[k]); end
      if (rdy) tx_data = tx_data + 8'd1;
    end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", tx_ready); end
    checks++; if (tx_data !== 8'h06) begin errors++; $display("FAIL full_accepts next=%h exp=06", tx_data); end
    for (int i = 0; i < 76; i++) begin
      tick(1);
      if (tx_ready !== 1'b0 || fifo_count !== 3'd4) held = 1'b1;
    end
    checks++; if (held !== 1'b0) begin errors++; $display("FAIL full_hold early=%b exp=0", held); end
    tick(1);
    checks++; if (tx_ready !== 1'b1 || fifo_count !== 3'd3) begin errors++; $display("FAIL full_reopen rdy=%b cnt=%0d exp 1/3", tx_ready, fifo_count); end
    tick(1);
    tx_valid = 1'b0;
    checks++; if (fifo_count !== 3'd4 || tx_ready !== 1'b0) begin errors++; $display("FAIL full_06 cnt=%0d rdy=%b exp 4/0", fifo_count, tx_ready); end
    tick(400);
    checks++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL full_drain busy=%b cnt=%0d exp 0/0", busy, fifo_count); end
    if (rx_q.size() != 6) ord = 1'b1;
    else for (int i = 0; i < 6; i++) if (rx_q[i] !== 8'(i + 1)) ord = 1'b1;
    checks++; if (ord !== 1'b0) begin errors++; $display("FAIL full_order n=%0d exp 6 bytes 01..06", rx_q.size()); end
    rx_q.delete();
    tick(5);
  endtask

  task automatic test_reset_mid;
    logic bad;
    bad = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    tick(1);
    tx_data = 8'h3C;
    tick(1);
    tx_valid = 1'b0;
    tick(34);
    checks++; if (busy !== 1'b1 || fifo_count !== 3'd1) begin errors++; $display("FAIL mid_pre busy=%b cnt=%0d exp 1/1", busy, fifo_count); end
    rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_tx got=%b exp=1", tx); end
    checks++; if (fifo_count !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL mid_clear cnt=%0d busy=%b exp 0/0", fifo_count, busy); end
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL mid_quiet activity=%b exp=0", bad); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_empty cnt=%0d exp=0", fifo_count); end
    rx_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_mid();
    checks++; if (frame_errs != 0) begin errors++; $display("FAIL stop_bits bad=%0d exp=0", frame_errs); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
